serial_cfg_tx: RTL and testbench

Host-side transmitter for the backend's serial configuration interface. On a start request it pulses the backend's active-low global reset, then shifts the 5-bit gain word (gainA1[2:0] followed by gainA2[1:0]) out on sclk/sdin, MSB first. It then waits for the backend ready flag and captures the VCO comparison result. It sits in the test/host controller and runs entirely in the i_clk domain.

---
 rtl/serial_cfg_tx.sv | 166 ++++++++++++++++
 tb/tb_serial_cfg_tx.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cfg_tx.sv
// serial_cfg_tx: host-side transmitter for the backend serial configuration
// interface. Each transaction pulses the backend's active-low reset, shifts
// the 5-bit gain word {gainA1, gainA2} out MSB first on o_sclk/o_sdin, then
// waits for the backend ready flag and captures the VCO comparison result.
//
// Handshake: a request is accepted on any rising edge of i_clk where
// i_start=1 and the FSM is IDLE (o_busy=0 in that cycle). The gain inputs
// are latched on that same edge. o_busy is high from the next cycle until
// the FSM returns to IDLE; i_start is ignored while o_busy=1. Completion is
// signalled by a one-cycle o_done pulse (ready seen) or by o_error rising
// (ready timeout); in both cases o_busy drops in that same cycle.
module serial_cfg_tx #(
  parameter int CLK_DIV       = 4,
  parameter int RST_CYCLES    = 4,
  parameter int READY_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [2:0] i_gainA1,
  input  logic [1:0] i_gainA2,
  input  logic       i_ready,
  input  logic       i_vco1_fast,
  output logic       o_resetbAll,
  output logic       o_sclk,
  output logic       o_sdin,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_vco1_fast,
  output logic       o_error,
  output logic [1:0] o_state
);

  // Counter widths; a counter that only ever holds 0 still gets one bit.
  localparam int PH_W   = $clog2(2 * CLK_DIV);
  localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WAIT_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;

  // Terminal counts. o_sclk rises when the phase counter leaves PH_MID and
  // falls when it wraps from PH_LAST, so the edge sits mid-bit.
  localparam logic [PH_W-1:0]   PH_MID    = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TIMEOUT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RST   = 2'd1,
    S_SHIFT = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [4:0]        r_word;
  logic [PH_W-1:0]   r_ph_cnt;
  logic [2:0]        r_bit_cnt;
  logic [RST_W-1:0]  r_rst_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_resetb;
  logic              r_sclk;
  logic              r_sdin;
  logic              r_busy;
  logic              r_done;
  logic              r_vco1_fast;
  logic              r_error;

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_ph_cnt    <= '0;
      r_bit_cnt   <= '0;
      r_rst_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_resetb    <= 1'b0;
      r_sclk      <= 1'b0;
      r_sdin      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vco1_fast <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_resetb <= 1'b1;
          r_sclk   <= 1'b0;
          r_sdin   <= 1'b0;
          r_busy   <= 1'b0;
          if (i_start) begin
            r_word    <= {i_gainA1, i_gainA2};
            r_error   <= 1'b0;
            r_resetb  <= 1'b0;
            r_busy    <= 1'b1;
            r_rst_cnt <= '0;
            r_state   <= S_RST;
          end
        end
        S_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            // Release the backend reset and present the MSB for bit 0.
            r_resetb  <= 1'b1;
            r_sdin    <= r_word[4];
            r_sclk    <= 1'b0;
            r_ph_cnt  <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
          end else begin
            r_rst_cnt <= r_rst_cnt + RST_W'(1);
          end
        end
        S_SHIFT: begin
          if (r_ph_cnt == PH_LAST) begin
            r_ph_cnt <= '0;
            r_sclk   <= 1'b0;
            if (r_bit_cnt == BIT_LAST) begin
              r_sdin     <= 1'b0;
              r_wait_cnt <= '0;
              r_state    <= S_WAIT;
            end else begin
              // Next bit goes out while the word shifts under it.
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_sdin    <= r_word[3];
              r_word    <= {r_word[3:0], 1'b0};
            end
          end else begin
            r_ph_cnt <= r_ph_cnt + PH_W'(1);
            if (r_ph_cnt == PH_MID) begin
              r_sclk <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (i_ready) begin
            r_vco1_fast <= i_vco1_fast;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_resetbAll = r_resetb;
  assign o_sclk      = r_sclk;
  assign o_sdin      = r_sdin;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_vco1_fast = r_vco1_fast;
  assign o_error     = r_error;
  assign o_state     = r_state;

endmodule

// File: tb/tb_serial_cfg_tx.sv
// Testbench for serial_cfg_tx: one instance with default parameters and one
// with CLK_DIV=1, RST_CYCLES=1. A backend shift-register model follows each
// serial link; expected bits and words are queued when a start is driven.
module tb_serial_cfg_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic i_reset;

  int n_checks = 0;
  int n_errors = 0;
  int t_start  = 0;

  // ---------------- DUT A (defaults) ----------------
  logic       a_start, a_ready, a_vco_in;
  logic [2:0] a_g1;
  logic [1:0] a_g2;
  logic       a_resetb, a_sclk, a_sdin, a_busy, a_done, a_vco, a_error;
  logic [1:0] a_state;

  serial_cfg_tx dut_a (
    .i_clk(clk), .i_reset(i_reset), .i_start(a_start),
    .i_gainA1(a_g1), .i_gainA2(a_g2), .i_ready(a_ready),
    .i_vco1_fast(a_vco_in), .o_resetbAll(a_resetb), .o_sclk(a_sclk),
    .o_sdin(a_sdin), .o_busy(a_busy), .o_done(a_done),
    .o_vco1_fast(a_vco), .o_error(a_error), .o_state(a_state)
  );

  // ---------------- DUT B (fast) ----------------
  logic       b_start, b_ready, b_vco_in;
  logic [2:0] b_g1;
  logic [1:0] b_g2;
  logic       b_resetb, b_sclk, b_sdin, b_busy, b_done, b_vco, b_error;
  logic [1:0] b_state;

  serial_cfg_tx #(.CLK_DIV(1), .RST_CYCLES(1), .READY_TIMEOUT(255)) dut_b (
    .i_clk(clk), .i_reset(i_reset), .i_start(b_start),
    .i_gainA1(b_g1), .i_gainA2(b_g2), .i_ready(b_ready),
    .i_vco1_fast(b_vco_in), .o_resetbAll(b_resetb), .o_sclk(b_sclk),
    .o_sdin(b_sdin), .o_busy(b_busy), .o_done(b_done),
    .o_vco1_fast(b_vco), .o_error(b_error), .o_state(b_state)
  );

  // ---------------- backend models ----------------
  logic [4:0] a_be_sr, b_be_sr;
  logic       a_be_q, b_be_q;

  // Backend A: cleared while reset is low, left-shifts on each sclk rise.
  always @(posedge clk) begin
    a_be_q <= a_sclk;
    if (a_resetb !== 1'b1) a_be_sr <= 5'd0;
    else if (a_sclk === 1'b1 && a_be_q !== 1'b1) a_be_sr <= {a_be_sr[3:0], a_sdin};
  end

  // Backend B: same model on the fast link.
  always @(posedge clk) begin
    b_be_q <= b_sclk;
    if (b_resetb !== 1'b1) b_be_sr <= 5'd0;
    else if (b_sclk === 1'b1 && b_be_q !== 1'b1) b_be_sr <= {b_be_sr[3:0], b_sdin};
  end

  // ---------------- scoreboards ----------------
  logic [0:0] a_exp_bits[$];
  logic [4:0] a_exp_word[$];
  logic [0:0] b_exp_bits[$];
  logic [4:0] b_exp_word[$];

  // Monitor A: checks sdin at each sclk rise and the backend word at done.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_sclk === 1'b1 && prev !== 1'b1) begin
        n_checks++;
        if (a_exp_bits.size() == 0) begin
          n_errors++;
          $display("FAIL a_sdin_edge: unexpected sclk rise at cycle %0d, none expected", cyc);
        end else begin
          if (a_sdin !== a_exp_bits[0]) begin
            n_errors++;
            $display("FAIL a_sdin_edge: cycle %0d sdin=%b expected %b", cyc, a_sdin, a_exp_bits[0]);
          end
          void'(a_exp_bits.pop_front());
        end
      end
      prev = a_sclk;
      if (a_done === 1'b1) begin
        n_checks++;
        if (a_exp_word.size() == 0) begin
          n_errors++;
          $display("FAIL a_word: done at cycle %0d with no expected word", cyc);
        end else begin
          if (a_be_sr !== a_exp_word[0]) begin
            n_errors++;
            $display("FAIL a_word: backend word=%b expected %b", a_be_sr, a_exp_word[0]);
          end
          void'(a_exp_word.pop_front());
        end
      end
    end
  end

  // Monitor B: same checks for the fast instance.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (b_sclk === 1'b1 && prev !== 1'b1) begin
        n_checks++;
        if (b_exp_bits.size() == 0) begin
          n_errors++;
          $display("FAIL b_sdin_edge: unexpected sclk rise at cycle %0d, none expected", cyc);
        end else begin
          if (b_sdin !== b_exp_bits[0]) begin
            n_errors++;
            $display("FAIL b_sdin_edge: cycle %0d sdin=%b expected %b", cyc, b_sdin, b_exp_bits[0]);
          end
          void'(b_exp_bits.pop_front());
        end
      end
      prev = b_sclk;
      if (b_done === 1'b1) begin
        n_checks++;
        if (b_exp_word.size() == 0) begin
          n_errors++;
          $display("FAIL b_word: done at cycle %0d with no expected word", cyc);
        end else begin
          if (b_be_sr !== b_exp_word[0]) begin
            n_errors++;
            $display("FAIL b_word: backend word=%b expected %b", b_be_sr, b_exp_word[0]);
          end
          void'(b_exp_word.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Start a transaction on DUT A; afterwards rel = cyc - t_start is the
  // cycle offset from the start cycle T when sampled on a falling edge.
  task automatic a_do_start(input logic [2:0] g1, input logic [1:0] g2);
    logic [4:0] w;
    w = {g1, g2};
    @(negedge clk);
    a_g1 = g1; a_g2 = g2; a_start = 1'b1;
    for (int k = 4; k >= 0; k--) a_exp_bits.push_back(w[k]);
    a_exp_word.push_back(w);
    @(posedge clk); #1;
    t_start = cyc - 1;
    a_start = 1'b0;
  endtask

  // Hold busy checks until ready_rel, raise ready there, check completion.
  task automatic a_finish_txn(input int ready_rel, input logic vco);
    logic busy_ok;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      if (a_busy !== 1'b1) busy_ok = 1'b0;
    end while (cyc - t_start < ready_rel);
    n_checks++;
    if (!busy_ok) begin
      n_errors++;
      $display("FAIL busy_hold: busy dropped before ready (got 0, expected 1)");
    end
    a_ready = 1'b1; a_vco_in = vco;
    @(negedge clk);
    n_checks++;
    if ({a_done, a_busy, a_vco, a_error} !== {1'b1, 1'b0, vco, 1'b0}) begin
      n_errors++;
      $display("FAIL done_pulse: rel %0d done/busy/vco/err=%b%b%b%b expected 10%b0",
               cyc - t_start, a_done, a_busy, a_vco, a_error, vco);
    end
    n_checks++;
    if (a_exp_bits.size() != 0) begin
      n_errors++;
      $display("FAIL edge_count: %0d bits left unsent, expected 0", a_exp_bits.size());
    end
    a_ready = 1'b0; a_vco_in = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_resetb, a_sclk, a_sdin, a_busy, a_done, a_vco, a_error, a_state} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_a: outputs=%b expected 000000000",
               {a_resetb, a_sclk, a_sdin, a_busy, a_done, a_vco, a_error, a_state});
    end
    n_checks++;
    if ({b_resetb, b_sclk, b_sdin, b_busy, b_done, b_vco, b_error, b_state} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_b: outputs=%b expected 000000000",
               {b_resetb, b_sclk, b_sdin, b_busy, b_done, b_vco, b_error, b_state});
    end
    i_reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_resetb, b_resetb, a_busy, b_busy} !== 4'b1100) begin
      n_errors++;
      $display("FAIL idle_resetb: resetb a/b busy a/b=%b expected 1100",
               {a_resetb, b_resetb, a_busy, b_busy});
    end
  endtask

  task automatic test_basic();
    logic [63:0] rst_m, edge_m, exp_rst, exp_edge;
    logic prev;
    rst_m = '0; edge_m = '0; exp_rst = '0; exp_edge = '0; prev = 1'b0;
    for (int r = 1; r <= 4; r++) exp_rst[r] = 1'b1;
    for (int e = 0; e < 5; e++) exp_edge[9 + 8 * e] = 1'b1;
    a_do_start(3'b101, 2'b10);
    for (int r = 1; r <= 50; r++) begin
      @(negedge clk);
      if (a_resetb !== 1'b1) rst_m[cyc - t_start] = 1'b1;
      if (a_sclk === 1'b1 && prev !== 1'b1) edge_m[cyc - t_start] = 1'b1;
      prev = a_sclk;
    end
    n_checks++;
    if (rst_m !== exp_rst) begin
      n_errors++;
      $display("FAIL resetb_window: low mask=%h expected %h", rst_m, exp_rst);
    end
    n_checks++;
    if (edge_m !== exp_edge) begin
      n_errors++;
      $display("FAIL sclk_edges: rise mask=%h expected %h", edge_m, exp_edge);
    end
    a_finish_txn(70, 1'b1);
    n_checks++;
    if ({a_be_sr[4:2], a_be_sr[1:0]} !== {3'd5, 2'd2}) begin
      n_errors++;
      $display("FAIL backend_gain: gainA1=%0d gainA2=%0d expected 5 2", a_be_sr[4:2], a_be_sr[1:0]);
    end
  endtask

  task automatic test_timeout();
    int   err_rel;
    logic saw_done;
    err_rel = -1; saw_done = 1'b0;
    a_do_start(3'b011, 2'b01);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (a_done === 1'b1) saw_done = 1'b1;
      if (a_error === 1'b1) begin
        err_rel = cyc - t_start;
        break;
      end
    end
    n_checks++;
    if (err_rel != 300) begin
      n_errors++;
      $display("FAIL timeout_cycle: error rose at rel %0d expected 300", err_rel);
    end
    n_checks++;
    if (saw_done !== 1'b0 || a_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_flags: done seen=%b busy=%b expected 0 0", saw_done, a_busy);
    end
    n_checks++;
    if (a_exp_word.size() == 0 || a_be_sr !== a_exp_word[0]) begin
      n_errors++;
      $display("FAIL timeout_word: backend word=%b expected 01101", a_be_sr);
    end
    if (a_exp_word.size() != 0) void'(a_exp_word.pop_front());
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_error !== 1'b1) begin
      n_errors++;
      $display("FAIL error_sticky: error=%b expected 1", a_error);
    end
    a_do_start(3'b111, 2'b00);
    @(negedge clk);
    n_checks++;
    if ({a_error, a_busy} !== 2'b01) begin
      n_errors++;
      $display("FAIL error_clear: error/busy=%b%b at T+1 expected 01", a_error, a_busy);
    end
    a_finish_txn(50, 1'b0);
  endtask

  task automatic test_ignore_start();
    a_do_start(3'b110, 2'b01);
    for (int r = 1; r <= 40; r++) begin
      @(negedge clk);
      if (r >= 10) begin
        a_start = 1'($urandom_range(0, 1));
        a_g1    = 3'($urandom_range(0, 7));
        a_g2    = 2'($urandom_range(0, 3));
      end
    end
    a_start = 1'b0;
    a_finish_txn(60, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0 || a_state !== 2'd0) begin
      n_errors++;
      $display("FAIL no_restart: busy=%b state=%0d expected 0 0", a_busy, a_state);
    end
  endtask

  task automatic test_reset_abort();
    logic quiet_ok;
    quiet_ok = 1'b1;
    a_do_start(3'b010, 2'b11);
    do @(negedge clk); while (cyc - t_start < 20);
    n_checks++;
    if (a_sclk !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_setup: sclk=%b at T+20 expected 1", a_sclk);
    end
    i_reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_resetb, a_sclk, a_sdin, a_busy, a_done, a_vco, a_error, a_state} !== 9'd0) begin
      n_errors++;
      $display("FAIL abort_reset: outputs=%b expected 000000000",
               {a_resetb, a_sclk, a_sdin, a_busy, a_done, a_vco, a_error, a_state});
    end
    n_checks++;
    if (a_exp_bits.size() != 3) begin
      n_errors++;
      $display("FAIL abort_edges: %0d bits unsent expected 3", a_exp_bits.size());
    end
    i_reset = 1'b0;
    a_exp_bits.delete();
    if (a_exp_word.size() != 0) void'(a_exp_word.pop_back());
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_sclk !== 1'b0 || a_busy !== 1'b0) quiet_ok = 1'b0;
    end
    n_checks++;
    if (!quiet_ok || a_resetb !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_quiet: activity after abort ok=%b resetb=%b expected 1 1", quiet_ok, a_resetb);
    end
    a_do_start(3'b001, 2'b01);
    a_finish_txn(48, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rst_m, edge_m, done_m, exp_rst, exp_edge, exp_done;
    logic [4:0]  w1, w2;
    logic        prev;
    int          t0;
    rst_m = '0; edge_m = '0; done_m = '0; prev = 1'b0;
    exp_rst = '0; exp_edge = '0; exp_done = '0;
    exp_rst[1] = 1'b1; exp_rst[14] = 1'b1;
    for (int e = 0; e < 5; e++) begin
      exp_edge[3 + 2 * e]  = 1'b1;
      exp_edge[16 + 2 * e] = 1'b1;
    end
    exp_done[13] = 1'b1; exp_done[26] = 1'b1;
    w1 = {3'b100, 2'b11};
    w2 = {3'b011, 2'b10};
    b_ready = 1'b1;
    @(negedge clk);
    b_g1 = w1[4:2]; b_g2 = w1[1:0]; b_start = 1'b1;
    for (int k = 4; k >= 0; k--) b_exp_bits.push_back(w1[k]);
    for (int k = 4; k >= 0; k--) b_exp_bits.push_back(w2[k]);
    b_exp_word.push_back(w1);
    b_exp_word.push_back(w2);
    @(posedge clk); #1;
    t0 = cyc - 1;
    for (int r = 1; r <= 30; r++) begin
      @(negedge clk);
      if (r == 1) begin
        b_g1 = w2[4:2]; b_g2 = w2[1:0];
      end
      if (b_resetb !== 1'b1) rst_m[cyc - t0] = 1'b1;
      if (b_sclk === 1'b1 && prev !== 1'b1) edge_m[cyc - t0] = 1'b1;
      prev = b_sclk;
      if (b_done === 1'b1) done_m[cyc - t0] = 1'b1;
      if (r == 14) b_start = 1'b0;
    end
    b_ready = 1'b0;
    n_checks++;
    if (rst_m !== exp_rst) begin
      n_errors++;
      $display("FAIL b2b_resetb: low mask=%h expected %h", rst_m, exp_rst);
    end
    n_checks++;
    if (edge_m !== exp_edge) begin
      n_errors++;
      $display("FAIL b2b_edges: rise mask=%h expected %h", edge_m, exp_edge);
    end
    n_checks++;
    if (done_m !== exp_done) begin
      n_errors++;
      $display("FAIL b2b_done: done mask=%h expected %h", done_m, exp_done);
    end
    n_checks++;
    if (b_exp_bits.size() != 0 || b_exp_word.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_drain: bits left %0d words left %0d expected 0 0",
               b_exp_bits.size(), b_exp_word.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_reset = 1'b1;
    a_start = 1'b0; a_ready = 1'b0; a_vco_in = 1'b0; a_g1 = 3'd0; a_g2 = 2'd0;
    b_start = 1'b0; b_ready = 1'b0; b_vco_in = 1'b0; b_g1 = 3'd0; b_g2 = 2'd0;
    test_reset();
    test_basic();
    test_timeout();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
